// File: rtl/mor1kx_irq_conditioner_pkg.sv
// Shared constants for the external interrupt conditioner.
package mor1kx_irq_conditioner_pkg;

    localparam int IRQ_NUM      = 32;
    localparam int FILTER_CNT_W = 8;

    typedef logic [FILTER_CNT_W-1:0] filter_cnt_t;
    typedef logic [IRQ_NUM-1:0]      irq_vec_t;

endpackage

// File: rtl/mor1kx_irq_filter_line.sv
// One interrupt line: optional synchroniser, stable-level glitch filter and
// rising-edge detector. Input is already polarity-normalised.
module mor1kx_irq_filter_line
    import mor1kx_irq_conditioner_pkg::*;
#(
    parameter bit SYNC_EN       = 1'b1,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    output logic o_level,
    output logic o_rise,
    output logic o_busy
);

    // A bypassed line still gets one register so every path is registered.
    localparam int STAGES = SYNC_EN ? SYNC_STAGES : 1;

    logic [STAGES-1:0] r_sync;
    logic              w_s;
    logic              w_level;
    logic              r_level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync[0] <= 1'b0;
        end else begin
            r_sync[0] <= i_irq;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync[gi] <= 1'b0;
                end else begin
                    r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_s = r_sync[STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_no_filter
            assign w_level = w_s;
            assign o_busy  = 1'b0;
        end else begin : g_filter
            localparam filter_cnt_t CNT_LAST = filter_cnt_t'(FILTER_CYCLES - 1);

            filter_cnt_t r_cnt;
            logic        r_level;

            // Counter tracks consecutive cycles of disagreement; it is
            // cleared on acceptance so it never passes CNT_LAST.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (w_s == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_level <= w_s;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_level = r_level;
            assign o_busy  = (r_cnt != '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_level_d;

endmodule

// File: rtl/mor1kx_irq_conditioner.sv
// Conditions the raw external interrupt lines (polarity, synchronisation,
// glitch filtering) before they reach the PIC.
module mor1kx_irq_conditioner
    import mor1kx_irq_conditioner_pkg::*;
#(
    parameter int          SYNC_STAGES    = 2,
    parameter logic [31:0] IRQ_SYNC_MASK  = 32'hffff_fffc,
    parameter logic [31:0] IRQ_ACTIVE_LOW = 32'h0000_0000,
    parameter int          FILTER_CYCLES  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] irq_raw_i,
    output logic [31:0] irq_o,
    output logic [31:0] irq_rise_o,
    output logic        irq_busy_o
);

    irq_vec_t w_norm;
    irq_vec_t w_busy;

    // Normalise before the first flop so idle active-low lines sync in as 0.
    assign w_norm = irq_raw_i ^ IRQ_ACTIVE_LOW;

    genvar gi;
    generate
        for (gi = 0; gi < IRQ_NUM; gi++) begin : g_line
            mor1kx_irq_filter_line #(
                .SYNC_EN       (IRQ_SYNC_MASK[gi]),
                .SYNC_STAGES   (SYNC_STAGES),
                .FILTER_CYCLES (FILTER_CYCLES)
            ) u_line (
                .clk     (clk),
                .rst     (rst),
                .i_irq   (w_norm[gi]),
                .o_level (irq_o[gi]),
                .o_rise  (irq_rise_o[gi]),
                .o_busy  (w_busy[gi])
            );
        end
    endgenerate

    assign irq_busy_o = |w_busy;

endmodule

// File: tb/tb_mor1kx_irq_conditioner.sv
// Drives three conditioner configurations (N=0/4/8) with directed and random
// stimulus and compares every cycle against a history-based reference model.
module tb_mor1kx_irq_conditioner;

    localparam int          SYNC   = 2;
    localparam logic [31:0] MASK   = 32'hffff_fffc;
    localparam int          NDUT   = 3;
    localparam int          N_C  [NDUT] = '{0, 4, 8};
    localparam logic [31:0] AL_C [NDUT] = '{32'h0000_0001, 32'h0, 32'h0};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] irq_raw;

    logic [31:0] dut_irq  [NDUT];
    logic [31:0] dut_rise [NDUT];
    logic        dut_busy [NDUT];

    always #5 clk = ~clk;

    mor1kx_irq_conditioner #(
        .SYNC_STAGES(SYNC), .IRQ_SYNC_MASK(MASK),
        .IRQ_ACTIVE_LOW(AL_C[0]), .FILTER_CYCLES(N_C[0])
    ) u_dut0 (
        .clk(clk), .rst(rst), .irq_raw_i(irq_raw),
        .irq_o(dut_irq[0]), .irq_rise_o(dut_rise[0]), .irq_busy_o(dut_busy[0])
    );

    mor1kx_irq_conditioner #(
        .SYNC_STAGES(SYNC), .IRQ_SYNC_MASK(MASK),
        .IRQ_ACTIVE_LOW(AL_C[1]), .FILTER_CYCLES(N_C[1])
    ) u_dut4 (
        .clk(clk), .rst(rst), .irq_raw_i(irq_raw),
        .irq_o(dut_irq[1]), .irq_rise_o(dut_rise[1]), .irq_busy_o(dut_busy[1])
    );

    mor1kx_irq_conditioner #(
        .SYNC_STAGES(SYNC), .IRQ_SYNC_MASK(MASK),
        .IRQ_ACTIVE_LOW(AL_C[2]), .FILTER_CYCLES(N_C[2])
    ) u_dut8 (
        .clk(clk), .rst(rst), .irq_raw_i(irq_raw),
        .irq_o(dut_irq[2]), .irq_rise_o(dut_rise[2]), .irq_busy_o(dut_busy[2])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: raw samples since the last reset, newest first.
    // Anything older than the last reset reads as 0 (synchronisers cleared).
    logic [31:0] raw_q[$];
    logic [31:0] m_f    [NDUT];
    logic [31:0] m_rise [NDUT];
    logic        m_busy [NDUT];

    function automatic logic nval(input int k, input int d, input int i);
        logic [31:0] al;
        logic [31:0] sample;
        al = AL_C[d];
        if (k >= raw_q.size()) return 1'b0;
        sample = raw_q[k];
        return sample[i] ^ al[i];
    endfunction

    task automatic model_update(input logic r, input logic [31:0] raw_v);
        if (r) begin
            raw_q.delete();
            for (int d = 0; d < NDUT; d++) begin
                m_f[d] = '0; m_rise[d] = '0; m_busy[d] = 1'b0;
            end
        end else begin
            raw_q.push_front(raw_v);
            if (raw_q.size() > 16) void'(raw_q.pop_back());
            for (int d = 0; d < NDUT; d++) begin
                logic [31:0] f_old;
                logic [31:0] f_new;
                logic        busy;
                f_old = m_f[d];
                f_new = f_old;
                busy  = 1'b0;
                for (int i = 0; i < 32; i++) begin
                    int lat;
                    lat = MASK[i] ? SYNC : 1;
                    if (N_C[d] == 0) begin
                        // Level seen lat edges after it was sampled.
                        f_new[i] = nval(lat - 1, d, i);
                    end else begin
                        // Accept only if the filter input disagreed for N edges in a row.
                        logic accept;
                        accept = 1'b1;
                        for (int k = 0; k < N_C[d]; k++)
                            if (nval(lat + k, d, i) == f_old[i]) accept = 1'b0;
                        if (accept) f_new[i] = ~f_old[i];
                        if (nval(lat, d, i) != f_new[i]) busy = 1'b1;
                    end
                end
                m_rise[d] = f_new & ~f_old;
                m_f[d]    = f_new;
                m_busy[d] = busy;
            end
        end
    endtask

    task automatic step(input logic r, input logic [31:0] raw_v);
        rst     = r;
        irq_raw = raw_v;
        @(posedge clk);
        model_update(r, raw_v);
        @(negedge clk);
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("irq_o N=%0d", N_C[d]),      dut_irq[d],  m_f[d]);
            check($sformatf("irq_rise_o N=%0d", N_C[d]), dut_rise[d], m_rise[d]);
            check($sformatf("irq_busy_o N=%0d", N_C[d]), {31'b0, dut_busy[d]}, {31'b0, m_busy[d]});
        end
    endtask

    task automatic hold(input int n, input logic [31:0] raw_v);
        for (int k = 0; k < n; k++) step(1'b0, raw_v);
    endtask

    logic [31:0] cur;

    initial begin
        rst     = 1'b1;
        irq_raw = 32'h1;
        @(negedge clk);

        // Reset with active-low line 0 idle high, then idle.
        for (int k = 0; k < 3; k++) step(1'b1, 32'h1);
        hold(6, 32'h1);

        // Sync latency on line 4, bypass latency on line 0.
        for (int k = 0; k < 2; k++) step(1'b1, 32'h0);
        hold(12, 32'h0000_0011);

        // Filter accept on line 5.
        for (int k = 0; k < 2; k++) step(1'b1, 32'h0);
        hold(14, 32'h0000_0020);

        // Glitch reject: three cycles high then low.
        hold(14, 32'h0);
        hold(3, 32'h0000_0020);
        hold(12, 32'h0);

        // Simultaneous falling line 7 and rising line 9.
        hold(14, 32'h0000_0080);
        hold(14, 32'h0000_0200);

        // Reset mid-count: dut N=8 counter reaches 5 after seven edges.
        for (int k = 0; k < 2; k++) step(1'b1, 32'h0);
        hold(7, 32'h0000_0020);
        for (int k = 0; k < 2; k++) step(1'b1, 32'h0000_0020);
        hold(14, 32'h0000_0020);

        // Random sparse toggling with occasional reset.
        cur = 32'h0;
        for (int k = 0; k < 600; k++) begin
            logic r;
            cur = cur ^ ($urandom & $urandom & $urandom);
            r   = ($urandom_range(0, 79) == 0);
            step(r, cur);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
